// File: rtl/keyslot_xor_engine_if.sv
// Bus bundle for keyslot_xor_engine: key provisioning, request/response
// handshake, scrub control and slot status.
interface keyslot_xor_engine_if #(
  parameter int KEY_W     = 32,
  parameter int DATA_W    = 8,
  parameter int NUM_SLOTS = 4
);
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                 key_load_valid;
  logic [SW-1:0]        key_load_slot;
  logic [KEY_W-1:0]     key_load_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [SW-1:0]        in_slot;
  logic [DATA_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [KEY_W-1:0]     out_data;
  logic                 out_err;
  logic                 scrub_req;
  logic                 scrub_busy;
  logic [NUM_SLOTS-1:0] slot_live;

  // Engine side
  modport slave (
    input  key_load_valid, key_load_slot, key_load_data,
    input  in_valid, in_slot, in_data, out_ready, scrub_req,
    output in_ready, out_valid, out_data, out_err, scrub_busy, slot_live
  );

  // Provisioning / producer / consumer side
  modport master (
    output key_load_valid, key_load_slot, key_load_data,
    output in_valid, in_slot, in_data, out_ready, scrub_req,
    input  in_ready, out_valid, out_data, out_err, scrub_busy, slot_live
  );
endinterface

// File: rtl/keyslot_xor_engine.sv
// Multi-slot keyed XOR engine. Each slot holds a key with a use budget;
// exhausted slots and consumed results are zeroed so no key material lingers.
//
// state | meaning
// IDLE  | no result held, ready for a request
// HOLD  | result registered, waiting for out_ready
// SCRUB | zeroing one slot per cycle, requests and loads blocked
module keyslot_xor_engine #(
  parameter int KEY_W     = 32,
  parameter int DATA_W    = 8,
  parameter int NUM_SLOTS = 4,
  parameter int MAX_USES  = 5
) (
  input logic clk,
  input logic rst,
  keyslot_xor_engine_if.slave bus
);
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(MAX_USES + 1);

  typedef enum logic [1:0] {IDLE, HOLD, SCRUB} state_t;

  state_t               state_q, state_d;
  logic [KEY_W-1:0]     key_q [NUM_SLOTS];
  logic [KEY_W-1:0]     key_d [NUM_SLOTS];
  logic [CW-1:0]        cnt_q [NUM_SLOTS];
  logic [CW-1:0]        cnt_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] live_q, live_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_err_q, out_err_d;
  logic [KEY_W-1:0]     out_data_q, out_data_d;
  logic [SW-1:0]        scrub_idx_q, scrub_idx_d;
  logic                 scrub_pend_q, scrub_pend_d;

  logic                 in_ready;
  logic                 accept;
  logic                 sel_live;
  logic [KEY_W-1:0]     sel_key;
  logic [CW-1:0]        sel_cnt;
  logic [CW-1:0]        sel_cnt_inc;
  logic [KEY_W-1:0]     cipher;

  // in_ready is held low while rst is asserted, whatever the old state was
  assign in_ready    = !rst && ((state_q == IDLE) || (state_q == HOLD && bus.out_ready));
  assign accept      = bus.in_valid && in_ready;
  assign sel_cnt_inc = sel_cnt + 1'b1;
  assign cipher      = sel_key ^ KEY_W'(bus.in_data);

  // Select the requested slot's key, count and liveness (pre-update values)
  always_comb begin
    sel_live = 1'b0;
    sel_key  = '0;
    sel_cnt  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (bus.in_slot == SW'(i)) begin
        sel_live = live_q[i];
        sel_key  = key_q[i];
        sel_cnt  = cnt_q[i];
      end
    end
  end

  // Next-state: FSM, result register, slot bookkeeping, scrub sequencing
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    cnt_d        = cnt_q;
    live_d       = live_q;
    out_valid_d  = out_valid_q;
    out_err_d    = out_err_q;
    out_data_d   = out_data_q;
    scrub_idx_d  = scrub_idx_q;
    scrub_pend_d = scrub_pend_q || (bus.scrub_req && state_q != SCRUB);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HOLD;
        end else if (scrub_pend_d) begin
          state_d      = SCRUB;
          scrub_idx_d  = '0;
          scrub_pend_d = 1'b0;
        end
      end
      HOLD: begin
        // A pending scrub waits until the held result drains
        if (bus.out_ready && !accept) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          out_data_d  = '0;
          if (scrub_pend_d) begin
            state_d      = SCRUB;
            scrub_idx_d  = '0;
            scrub_pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SCRUB: begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (scrub_idx_q == SW'(i)) begin
            key_d[i]  = '0;
            cnt_d[i]  = '0;
            live_d[i] = 1'b0;
          end
        end
        if (scrub_idx_q == SW'(NUM_SLOTS - 1)) begin
          state_d     = IDLE;
          scrub_idx_d = '0;
        end else begin
          scrub_idx_d = scrub_idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      if (sel_live) begin
        out_data_d = cipher;
        out_err_d  = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (bus.in_slot == SW'(i)) begin
            if (sel_cnt_inc == CW'(MAX_USES)) begin
              key_d[i]  = '0;
              cnt_d[i]  = '0;
              live_d[i] = 1'b0;
            end else begin
              cnt_d[i] = sel_cnt_inc;
            end
          end
        end
      end else begin
        out_data_d = '0;
        out_err_d  = 1'b1;
      end
    end

    // Load applied last so it overrides a same-slot accept's bookkeeping
    if (bus.key_load_valid && state_q != SCRUB) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (bus.key_load_slot == SW'(i)) begin
          key_d[i]  = bus.key_load_data;
          cnt_d[i]  = '0;
          live_d[i] = 1'b1;
        end
      end
    end
  end

  // State and storage registers, synchronously cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      live_q       <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_data_q   <= '0;
      scrub_idx_q  <= '0;
      scrub_pend_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        key_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      live_q       <= live_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      out_data_q   <= out_data_d;
      scrub_idx_q  <= scrub_idx_d;
      scrub_pend_q <= scrub_pend_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        key_q[i] <= key_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_err    = out_err_q;
  assign bus.scrub_busy = (state_q == SCRUB);
  assign bus.slot_live  = live_q;
endmodule

// File: tb/tb_keyslot_xor_engine.sv
// Directed bench for keyslot_xor_engine with a queue-based scoreboard.
module tb_keyslot_xor_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_res  = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  keyslot_xor_engine_if #(.KEY_W(32), .DATA_W(8), .NUM_SLOTS(4)) bus ();

  keyslot_xor_engine #(
    .KEY_W(32), .DATA_W(8), .NUM_SLOTS(4), .MAX_USES(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare every consumed result; idle output must be zero
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      n_vec++;
      n_res++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL result%0d: unexpected output err=%0b data=%h", n_res, bus.out_err, bus.out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.out_err !== e.err || bus.out_data !== e.data) begin
          n_miss++;
          $display("FAIL result%0d: got err=%0b data=%h, want err=%0b data=%h",
                   n_res, bus.out_err, bus.out_data, e.err, e.data);
        end
      end
    end else if (!bus.out_valid) begin
      n_vec++;
      if (bus.out_data !== 32'h0) begin
        n_miss++;
        $display("FAIL idle_out_data: got %h, want 00000000", bus.out_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [1:0] slot, input logic [31:0] data);
    bus.key_load_valid = 1'b1;
    bus.key_load_slot  = slot;
    bus.key_load_data  = data;
    tick(1);
    bus.key_load_valid = 1'b0;
  endtask

  // Present a request until accepted; returns at posedge+1 of the accepting edge
  task automatic send(input logic [1:0] slot, input logic [7:0] data,
                      input logic e_err, input logic [31:0] e_data);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_slot  = slot;
    bus.in_data  = data;
    sb.push_back('{err: e_err, data: e_data});
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout: slot %0d never accepted, want accept within 20 cycles", slot);
    end
  endtask

  initial begin
    logic [3:0] live_exp;
    bus.key_load_valid = 1'b0;
    bus.key_load_slot  = '0;
    bus.key_load_data  = '0;
    bus.in_valid       = 1'b0;
    bus.in_slot        = '0;
    bus.in_data        = '0;
    bus.out_ready      = 1'b1;
    bus.scrub_req      = 1'b0;

    // Reset
    @(negedge clk);
    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'h0);
    tick(2);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("reset_out_err", {31'b0, bus.out_err}, 32'h0);
    chk("reset_slot_live", {28'b0, bus.slot_live}, 32'h0);
    chk("reset_scrub_busy", {31'b0, bus.scrub_busy}, 32'h0);
    rst = 1'b0;
    tick(1);
    chk("idle_in_ready", {31'b0, bus.in_ready}, 32'h1);

    // Basic encryption
    load(2'd1, 32'hA5A5_0000);
    send(2'd1, 8'h3C, 1'b0, 32'hA5A5_003C);
    chk("basic_out_valid", {31'b0, bus.out_valid}, 32'h1);
    tick(1);
    chk("basic_drain_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("basic_drain_data", bus.out_data, 32'h0);

    // Use budget on slot0, back-to-back
    load(2'd0, 32'h1234_5678);
    send(2'd0, 8'h01, 1'b0, 32'h1234_5679);
    chk("budget_live1", {28'b0, bus.slot_live}, 32'h3);
    send(2'd0, 8'h02, 1'b0, 32'h1234_567A);
    send(2'd0, 8'h03, 1'b0, 32'h1234_567B);
    send(2'd0, 8'h04, 1'b0, 32'h1234_567C);
    chk("budget_live4", {28'b0, bus.slot_live}, 32'h3);
    send(2'd0, 8'h05, 1'b0, 32'h1234_567D);
    chk("budget_live5", {28'b0, bus.slot_live}, 32'h2);
    send(2'd0, 8'h06, 1'b1, 32'h0);
    tick(1);

    // Backpressure then back-to-back without a bubble
    bus.out_ready = 1'b0;
    send(2'd1, 8'h11, 1'b0, 32'hA5A5_0011);
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", {31'b0, bus.in_ready}, 32'h0);
      chk("stall_out_data", bus.out_data, 32'hA5A5_0011);
      chk("stall_out_valid", {31'b0, bus.out_valid}, 32'h1);
      tick(1);
    end
    bus.out_ready = 1'b1;
    send(2'd1, 8'h22, 1'b0, 32'hA5A5_0022);
    chk("b2b_out_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("b2b_out_data", bus.out_data, 32'hA5A5_0022);
    tick(1);

    // Same-cycle load and request on slot2
    load(2'd2, 32'h0000_00F0);
    bus.key_load_valid = 1'b1;
    bus.key_load_slot  = 2'd2;
    bus.key_load_data  = 32'hFFFF_FFFF;
    send(2'd2, 8'h0F, 1'b0, 32'h0000_00FF);
    bus.key_load_valid = 1'b0;
    send(2'd2, 8'h00, 1'b0, 32'hFFFF_FFFF);
    send(2'd2, 8'h01, 1'b0, 32'hFFFF_FFFE);
    send(2'd2, 8'h02, 1'b0, 32'hFFFF_FFFD);
    send(2'd2, 8'h03, 1'b0, 32'hFFFF_FFFC);
    chk("reload_live_after4", {31'b0, bus.slot_live[2]}, 32'h1);
    send(2'd2, 8'h04, 1'b0, 32'hFFFF_FFFB);
    chk("reload_live_after5", {31'b0, bus.slot_live[2]}, 32'h0);
    send(2'd2, 8'h55, 1'b1, 32'h0);
    tick(1);

    // Scrub
    load(2'd0, 32'h1111_1111);
    load(2'd1, 32'h2222_2222);
    load(2'd2, 32'h3333_3333);
    load(2'd3, 32'h4444_4444);
    chk("scrub_pre_live", {28'b0, bus.slot_live}, 32'hF);
    bus.scrub_req = 1'b1;
    tick(1);
    bus.scrub_req = 1'b0;
    live_exp = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      chk("scrub_busy", {31'b0, bus.scrub_busy}, 32'h1);
      chk("scrub_in_ready", {31'b0, bus.in_ready}, 32'h0);
      chk("scrub_live", {28'b0, bus.slot_live}, {28'b0, live_exp});
      if (k == 1) begin
        bus.key_load_valid = 1'b1;
        bus.key_load_slot  = 2'd0;
        bus.key_load_data  = 32'hDEAD_BEEF;
      end
      tick(1);
      bus.key_load_valid = 1'b0;
      live_exp = live_exp << 1;
    end
    chk("scrub_done_busy", {31'b0, bus.scrub_busy}, 32'h0);
    chk("scrub_done_live", {28'b0, bus.slot_live}, 32'h0);
    send(2'd0, 8'h01, 1'b1, 32'h0);
    send(2'd3, 8'h01, 1'b1, 32'h0);
    tick(1);

    // Reset while holding a result
    load(2'd1, 32'hCAFE_0000);
    bus.out_ready = 1'b0;
    send(2'd1, 8'h01, 1'b0, 32'hCAFE_0001);
    chk("prereset_out_valid", {31'b0, bus.out_valid}, 32'h1);
    void'(sb.pop_back());
    rst = 1'b1;
    tick(1);
    chk("midreset_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("midreset_out_data", bus.out_data, 32'h0);
    chk("midreset_out_err", {31'b0, bus.out_err}, 32'h0);
    chk("midreset_live", {28'b0, bus.slot_live}, 32'h0);
    chk("midreset_in_ready", {31'b0, bus.in_ready}, 32'h0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(2'd1, 8'h01, 1'b1, 32'h0);
    tick(3);

    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/keyslot_xor_engine.md
Name: keyslot_xor_engine

Overview:
- Multi-slot keyed XOR encryption engine; generalised successor of the single-key XOR/use-counter block.
- Holds NUM_SLOTS independent keys, each with its own use budget. Encrypts DATA_W-bit words under valid/ready handshakes.
- Zeroes every key slot and output holding register once it is exhausted or consumed, so no secret material persists after use.
- Sits between the key-provisioning path and the datapath consumer.

Parameters:
- KEY_W, 32, key and output width in bits (KEY_W >= DATA_W).
- DATA_W, 8, plaintext width; zero-extended to KEY_W before XOR.
- NUM_SLOTS, 4, number of key slots (>= 2); slot index width SW = $clog2(NUM_SLOTS).
- MAX_USES, 5, encryptions allowed per key load (1..255); counter width CW = $clog2(MAX_USES+1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- key_load_valid  in  1  write key_load_data into key_load_slot
- key_load_slot  in  SW  target slot
- key_load_data  in  KEY_W  key value
- in_valid  in  1  encryption request
- in_ready  out  1  engine can accept a request this cycle
- in_slot  in  SW  key slot to use
- in_data  in  DATA_W  plaintext
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- out_data  out  KEY_W  ciphertext; zero whenever out_valid=0 or out_err=1
- out_err  out  1  request hit an empty or exhausted slot
- scrub_req  in  1  pulse: zero all slots
- scrub_busy  out  1  scrub in progress
- slot_live  out  NUM_SLOTS  bit i=1 when slot i holds a usable key

Behaviour:
- Reset (rst=1 at posedge): all keys, use counters, slot_live, out_data, out_valid, out_err, scrub_busy = 0; FSM = IDLE. in_ready = 0 during the reset cycle.
- FSM states are IDLE, HOLD and SCRUB.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is combinational and never depends on in_valid.
- Accept: in_valid && in_ready at posedge. Next cycle out_valid=1 and state=HOLD (latency 1).
  - If slot_live[in_slot]: out_data = key[in_slot] ^ {0, in_data}, out_err=0, and counter[in_slot] increments.
  - Otherwise: out_data=0, out_err=1, and the counter is unchanged.
- Exhaustion: when an accepted request raises counter[s] to MAX_USES, key[s] is zeroed, slot_live[s] clears, and counter[s] resets to 0 in that same posedge. That request still returns valid ciphertext.
- HOLD: out_data and out_err are stable until out_ready.
  - On out_ready with no new accept: out_valid=0, out_data=0, out_err=0, state→IDLE.
  - On out_ready with a same-cycle accept: back-to-back, stay in HOLD with the new result.
- Key load (outside SCRUB): key[slot] = data, counter[slot]=0, slot_live[slot]=1.
  - A load to the same slot as a same-cycle accept: the accept uses the old key and old liveness. The load then wins, so counter=0 and live=1.
  - A load to a slot other than the accepted one: both take effect independently.
- Scrub: scrub_req in IDLE or HOLD moves to SCRUB on the next cycle, or once HOLD drains if out_valid=1. scrub_req is latched until SCRUB is entered.
  - In SCRUB, scrub_busy=1 and in_ready=0. Key loads are ignored. One slot is zeroed per cycle, index 0..NUM_SLOTS-1, so SCRUB lasts NUM_SLOTS cycles.
  - Each zeroed slot clears its slot_live bit and its counter.
  - Exit to IDLE after the final slot; scrub_busy falls the same cycle.
  - scrub_req asserted during SCRUB is ignored.
- Reset mid-operation: takes effect at that posedge regardless of state. Any in-flight result is dropped and out_data returns to zero.
- No combinational path from key storage to out_data; out_data is always the registered holding value.

Test Plan:
- Load slot1=0xA5A5_0000, send in_slot=1, in_data=0x3C, out_ready=1 → next cycle out_valid=1, out_data=0xA5A5_003C, out_err=0; the following idle cycle out_data=0.
- Load slot0=0x1234_5678, issue 5 back-to-back requests with data 0x01..0x05 → five correct ciphertexts, slot_live[0] drops after the 5th accept. A 6th request → out_err=1, out_data=0.
- out_ready=0 for 3 cycles while out_valid=1 → in_ready=0 and out_data stable. Raise out_ready together with a new in_valid → back-to-back result, no bubble.
- Same-cycle key_load slot2=0xFFFF_FFFF and request on slot2 (old key 0x0000_00F0, data 0x0F) → out_data=0x0000_00FF. Afterwards slot2 holds 0xFFFF_FFFF with counter 0.
- Load all 4 slots, pulse scrub_req → scrub_busy high exactly 4 cycles, slot_live goes 1111→0000 one bit per cycle, a key_load issued during scrub is ignored, and a subsequent request → out_err=1.
- Assert rst while out_valid=1 in HOLD → next cycle all outputs 0 and slot_live=0; a request on the previously loaded slot → out_err=1.
